// File: rtl/mod_n_updown_counter_pkg.sv
// rtl/mod_n_updown_counter_pkg.sv - mode encodings and elaboration helpers for the mod-N counter
package mod_n_updown_counter_pkg;

   localparam int MODE_WRAP   = 0;
   localparam int MODE_SAT    = 1;
   localparam int MODE_BOUNCE = 2;

   // Smallest r with 2**r >= value; used to check WIDTH against MODULUS.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((longint'(1) << result) < longint'(value)) begin
         result++;
      end
      return result;
   endfunction

endpackage

// File: rtl/mod_n_updown_counter_next_value.sv
// rtl/mod_n_updown_counter_next_value.sv - combinational step logic (next count, next dir, wrap)
module mod_n_next_value
   import mod_n_updown_counter_pkg::*;
#(
   parameter int MODULUS = 13,
   parameter int WIDTH   = 4,
   parameter int MODE    = MODE_WRAP
) (
   input  logic [WIDTH-1:0] count,
   input  logic             dir,
   input  logic             x,
   output logic [WIDTH:0]   next_count,
   output logic             next_dir,
   output logic             next_wrap,
   output logic             at_bound
);

   localparam logic [WIDTH:0] LAST = (WIDTH+1)'(MODULUS - 1);

   logic [WIDTH:0] cur;
   logic [WIDTH:0] plus1;
   logic [WIDTH:0] minus1;
   logic           up;

   assign cur    = {1'b0, count};
   assign plus1  = cur + 1'b1;
   assign minus1 = cur - 1'b1;

   // Bounce mode steps by its own direction register; the other modes follow x.
   assign up       = (MODE == MODE_BOUNCE) ? dir : x;
   assign at_bound = up ? (cur == LAST) : (cur == '0);

   // One enabled step for the selected mode, with the event that raises wrap.
   always_comb begin
      next_count = cur;
      next_dir   = up;
      next_wrap  = 1'b0;
      case (MODE)
         MODE_SAT: begin
            if (up) begin
               if (cur != LAST) begin
                  next_count = plus1;
                  next_wrap  = (plus1 == LAST);
               end
            end else begin
               if (cur != '0) begin
                  next_count = minus1;
                  next_wrap  = (minus1 == '0);
               end
            end
         end
         MODE_BOUNCE: begin
            if (up) begin
               if (cur == LAST) begin
                  next_count = minus1;
                  next_dir   = 1'b0;
                  next_wrap  = 1'b1;
               end else begin
                  next_count = plus1;
               end
            end else begin
               if (cur == '0) begin
                  next_count = plus1;
                  next_dir   = 1'b1;
                  next_wrap  = 1'b1;
               end else begin
                  next_count = minus1;
               end
            end
         end
         default: begin
            if (up) begin
               next_count = (cur == LAST) ? '0 : plus1;
               next_wrap  = (cur == LAST);
            end else begin
               next_count = (cur == '0) ? LAST : minus1;
               next_wrap  = (cur == '0);
            end
         end
      endcase
   end

endmodule

// File: rtl/mod_n_updown_counter.sv
// rtl/mod_n_updown_counter.sv - mod-N up/down counter with wrap, saturate and bounce modes
module mod_n_updown_counter
   import mod_n_updown_counter_pkg::*;
#(
   parameter int MODULUS = 13,
   parameter int WIDTH   = 4,
   parameter int MODE    = MODE_WRAP
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             x,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] count,
   output logic             dir,
   output logic             tc,
   output logic             wrap,
   output logic             load_err
);

   localparam logic [WIDTH:0] MOD_W = (WIDTH+1)'(MODULUS);

   generate
      if (MODULUS < 2 || MODULUS > 65536 || WIDTH < clog2(MODULUS) ||
          MODE < MODE_WRAP || MODE > MODE_BOUNCE) begin : g_bad_params
         $error("mod_n_updown_counter: illegal MODULUS/WIDTH/MODE combination");
      end
   endgenerate

   logic [1:0]       rst_sync_q, rst_sync_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             dir_q, dir_d;
   logic             wrap_q, wrap_d;
   logic             load_err_q, load_err_d;

   logic [WIDTH:0]   step_count;
   logic             step_dir;
   logic             step_wrap;
   logic             run;

   mod_n_next_value #(
      .MODULUS (MODULUS),
      .WIDTH   (WIDTH),
      .MODE    (MODE)
   ) u_next (
      .count      (count_q),
      .dir        (dir_q),
      .x          (x),
      .next_count (step_count),
      .next_dir   (step_dir),
      .next_wrap  (step_wrap),
      .at_bound   (tc)
   );

   // Reset release is retimed through two flops; state only advances once it emerges.
   assign rst_sync_d = {rst_sync_q[0], 1'b1};
   assign run        = rst_sync_q[1];

   // Per-cycle priority: load, then enabled step, then hold.
   always_comb begin
      count_d    = count_q;
      dir_d      = dir_q;
      wrap_d     = 1'b0;
      load_err_d = 1'b0;
      if (load) begin
         if ({1'b0, din} < MOD_W) begin
            count_d = din;
         end else begin
            load_err_d = 1'b1;
         end
      end else if (en) begin
         // The step never leaves range; the guard keeps an out-of-range value from ever landing.
         if (step_count < MOD_W) begin
            count_d = step_count[WIDTH-1:0];
         end
         dir_d  = step_dir;
         wrap_d = step_wrap;
      end
   end

   // Reset synchronizer: asserts immediately, releases on clk.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= rst_sync_d;
      end
   end

   // Counter state; reset wins at once and discards anything in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q    <= '0;
         dir_q      <= 1'b1;
         wrap_q     <= 1'b0;
         load_err_q <= 1'b0;
      end else if (run) begin
         count_q    <= count_d;
         dir_q      <= dir_d;
         wrap_q     <= wrap_d;
         load_err_q <= load_err_d;
      end
   end

   assign count    = count_q;
   assign dir      = dir_q;
   assign wrap     = wrap_q;
   assign load_err = load_err_q;

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// tb/tb_mod_n_updown_counter.sv - directed bench for the mod-N counter in all three modes
module tb_mod_n_updown_counter;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       x;
   logic       load;
   logic [3:0] din;

   logic [3:0] cnt [3];
   logic       dr  [3];
   logic       tcv [3];
   logic       wr  [3];
   logic       le  [3];

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   // Index 0 = wrap, 1 = saturate, 2 = bounce; all share one stimulus stream.
   for (genvar g = 0; g < 3; g++) begin : g_dut
      mod_n_updown_counter #(
         .MODULUS (13),
         .WIDTH   (4),
         .MODE    (g)
      ) u_dut (
         .clk      (clk),
         .rst      (rst),
         .en       (en),
         .x        (x),
         .load     (load),
         .din      (din),
         .count    (cnt[g]),
         .dir      (dr[g]),
         .tc       (tcv[g]),
         .wrap     (wr[g]),
         .load_err (le[g])
      );
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; en = 1'b0; x = 1'b1; load = 1'b0; din = 4'd0;
      repeat (2) tick();
      for (int i = 0; i < 3; i++) begin
         tests_run++;
         if (cnt[i] !== 4'd0 || dr[i] !== 1'b1 || wr[i] !== 1'b0 || le[i] !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state[%0d]: got count=%0d dir=%b wrap=%b load_err=%b, expected 0 1 0 0",
                     i, cnt[i], dr[i], wr[i], le[i]);
         end
      end
      // Release between edges with en already high: no step until the release is synchronized.
      rst = 1'b1; en = 1'b1; x = 1'b1;
      for (int k = 1; k <= 2; k++) begin
         tick();
         for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (cnt[i] !== 4'd0) begin
               tests_failed++;
               $display("FAIL release_hold%0d[%0d]: got count=%0d, expected 0", k, i, cnt[i]);
            end
         end
      end
      en = 1'b0;
      tick();
   endtask

   task automatic test_bounce();
      int p;
      logic [3:0] e_cnt;
      logic e_dir, e_wrap, e_tc;
      en = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         x = k[0];
         tick();
         p      = k % 24;
         e_cnt  = (p <= 12) ? 4'(p) : 4'(24 - p);
         e_dir  = (p >= 1 && p <= 12);
         e_wrap = (p == 13) || (p == 1 && k > 24);
         e_tc   = (p == 12) || (p == 0);
         tests_run++;
         if (cnt[2] !== e_cnt || dr[2] !== e_dir || wr[2] !== e_wrap || tcv[2] !== e_tc) begin
            tests_failed++;
            $display("FAIL bounce_step%0d: got count=%0d dir=%b wrap=%b tc=%b, expected %0d %b %b %b",
                     k, cnt[2], dr[2], wr[2], tcv[2], e_cnt, e_dir, e_wrap, e_tc);
         end
      end
      en = 1'b0;
   endtask

   task automatic test_wrap_down();
      logic [3:0] e_cnt;
      load = 1'b1; din = 4'd0; en = 1'b0;
      tick();
      load = 1'b0; x = 1'b0;
      #1;
      tests_run++;
      if (tcv[0] !== 1'b1) begin
         tests_failed++;
         $display("FAIL tc_down_at_0: got %b, expected 1", tcv[0]);
      end
      en = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         tick();
         e_cnt = 4'((13 - (k % 13)) % 13);
         tests_run++;
         if (cnt[0] !== e_cnt || wr[0] !== (e_cnt == 4'd12) || dr[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_down_step%0d: got count=%0d wrap=%b dir=%b, expected %0d %b 0",
                     k, cnt[0], wr[0], dr[0], e_cnt, (e_cnt == 4'd12));
         end
      end
      en = 1'b0;
   endtask

   task automatic test_wrap_up();
      logic [3:0] e_cnt;
      load = 1'b1; din = 4'd0; en = 1'b0;
      tick();
      load = 1'b0; x = 1'b1;
      #1;
      tests_run++;
      if (tcv[0] !== 1'b0) begin
         tests_failed++;
         $display("FAIL tc_up_at_0: got %b, expected 0", tcv[0]);
      end
      en = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         tick();
         e_cnt = 4'(k % 13);
         tests_run++;
         if (cnt[0] !== e_cnt || wr[0] !== (e_cnt == 4'd0) || tcv[0] !== (e_cnt == 4'd12) ||
             dr[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap_up_step%0d: got count=%0d wrap=%b tc=%b dir=%b, expected %0d %b %b 1",
                     k, cnt[0], wr[0], tcv[0], dr[0], e_cnt, (e_cnt == 4'd0), (e_cnt == 4'd12));
         end
      end
      en = 1'b0;
   endtask

   task automatic test_saturate();
      logic [3:0] e_cnt;
      load = 1'b1; din = 4'd10; en = 1'b0;
      tick();
      load = 1'b0;
      tests_run++;
      if (cnt[1] !== 4'd10) begin
         tests_failed++;
         $display("FAIL sat_load10: got %0d, expected 10", cnt[1]);
      end
      x = 1'b1; en = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         e_cnt = (k == 1) ? 4'd11 : 4'd12;
         tests_run++;
         if (cnt[1] !== e_cnt || wr[1] !== (k == 2)) begin
            tests_failed++;
            $display("FAIL sat_up_step%0d: got count=%0d wrap=%b, expected %0d %b",
                     k, cnt[1], wr[1], e_cnt, (k == 2));
         end
      end
      tests_run++;
      if (tcv[1] !== 1'b1) begin
         tests_failed++;
         $display("FAIL sat_tc_at_12: got %b, expected 1", tcv[1]);
      end
      load = 1'b1; din = 4'd1; en = 1'b0;
      tick();
      load = 1'b0; x = 1'b0; en = 1'b1;
      for (int k = 1; k <= 2; k++) begin
         tick();
         tests_run++;
         if (cnt[1] !== 4'd0 || wr[1] !== (k == 1) || dr[1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL sat_down_step%0d: got count=%0d wrap=%b dir=%b, expected 0 %b 0",
                     k, cnt[1], wr[1], dr[1], (k == 1));
         end
      end
      en = 1'b0;
   endtask

   task automatic test_load();
      logic [3:0] vec_din  [4] = '{4'd7, 4'd13, 4'd12, 4'd15};
      logic [3:0] vec_cnt  [4] = '{4'd7, 4'd7,  4'd12, 4'd12};
      logic       vec_err  [4] = '{1'b0, 1'b1,  1'b0,  1'b1};
      en = 1'b1; x = 1'b1;
      for (int v = 0; v < 4; v++) begin
         load = 1'b1; din = vec_din[v];
         tick();
         for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (cnt[i] !== vec_cnt[v] || le[i] !== vec_err[v] || wr[i] !== 1'b0) begin
               tests_failed++;
               $display("FAIL load_din%0d[%0d]: got count=%0d load_err=%b wrap=%b, expected %0d %b 0",
                        vec_din[v], i, cnt[i], le[i], wr[i], vec_cnt[v], vec_err[v]);
            end
         end
      end
      load = 1'b0; en = 1'b0;
      tick();
      tests_run++;
      if (le[0] !== 1'b0 || cnt[0] !== 4'd12) begin
         tests_failed++;
         $display("FAIL load_err_one_cycle: got load_err=%b count=%0d, expected 0 12", le[0], cnt[0]);
      end
   endtask

   task automatic test_async_reset();
      load = 1'b1; din = 4'd5; en = 1'b0;
      tick();
      load = 1'b0; en = 1'b1; x = 1'b0;
      tick();
      tests_run++;
      if (cnt[0] !== 4'd4 || dr[0] !== 1'b0) begin
         tests_failed++;
         $display("FAIL pre_reset_step: got count=%0d dir=%b, expected 4 0", cnt[0], dr[0]);
      end
      en = 1'b0; load = 1'b1; din = 4'd13;
      tick();
      tests_run++;
      if (le[0] !== 1'b1) begin
         tests_failed++;
         $display("FAIL pre_reset_load_err: got %b, expected 1", le[0]);
      end
      // Pending load of 9 is in place when reset drops between edges.
      din = 4'd9; en = 1'b1;
      #2 rst = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         tests_run++;
         if (cnt[i] !== 4'd0 || dr[i] !== 1'b1 || wr[i] !== 1'b0 || le[i] !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset[%0d]: got count=%0d dir=%b wrap=%b load_err=%b, expected 0 1 0 0",
                     i, cnt[i], dr[i], wr[i], le[i]);
         end
      end
      tick();
      tests_run++;
      if (cnt[0] !== 4'd0) begin
         tests_failed++;
         $display("FAIL reset_discards_load: got %0d, expected 0", cnt[0]);
      end
      #2 rst = 1'b1;
      load = 1'b0; en = 1'b1; x = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         tests_run++;
         if (cnt[0] !== ((k <= 2) ? 4'd0 : 4'(k - 2))) begin
            tests_failed++;
            $display("FAIL resume_step%0d: got %0d, expected %0d",
                     k, cnt[0], ((k <= 2) ? 0 : k - 2));
         end
      end
      en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_bounce();
      test_wrap_down();
      test_wrap_up();
      test_saturate();
      test_load();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
